// File: rtl/pipe_chain.sv
// Elastic register pipeline with valid/ready handshake, synchronous flush and an
// optional bit reversal of the low data field on the output.
module pipe_chain #(
    parameter int unsigned WIDTH  = 6,
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned LO_W   = 3,
    parameter int unsigned REV_LO = 1
) (
    input  logic                         clk,
    input  logic                         rst_l,
    input  logic                         in_vld,
    output logic                         in_rdy,
    input  logic [WIDTH-1:0]             in_data,
    input  logic                         flush,
    output logic                         out_vld,
    input  logic                         out_rdy,
    output logic [WIDTH-1:0]             out_data,
    output logic [$clog2(DEPTH+1)-1:0]   occ
);

    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] vld_q;
    logic [WIDTH-1:0] dat_q   [DEPTH];
    logic [DEPTH:0]   rdy;
    logic [DEPTH-1:0] src_vld;
    logic [WIDTH-1:0] src_dat [DEPTH];
    logic [WIDTH-1:0] last;

    // Ready ripples back from the output; a stage may load when empty or draining.
    always_comb begin
        rdy[DEPTH] = out_rdy;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            rdy[k] = !vld_q[k] | rdy[k+1];
        end
    end

    assign in_rdy = rdy[0] & !flush & rst_l;

    always_comb begin
        src_vld[0] = in_vld & in_rdy;
        src_dat[0] = in_data;
        for (int k = 1; k < DEPTH; k++) begin
            src_vld[k] = vld_q[k-1];
            src_dat[k] = dat_q[k-1];
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            vld_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                dat_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                if (flush) begin
                    vld_q[k] <= 1'b0;
                end else if (rdy[k]) begin
                    vld_q[k] <= src_vld[k];
                end
                // Data only moves with a valid word, so empty stages never toggle.
                if (rdy[k] && src_vld[k] && !flush) begin
                    dat_q[k] <= src_dat[k];
                end
            end
        end
    end

    assign last    = dat_q[DEPTH-1];
    assign out_vld = vld_q[DEPTH-1];

    always_comb begin
        out_data = last;
        if (REV_LO != 0) begin
            for (int i = 0; i < int'(LO_W); i++) begin
                out_data[i] = last[int'(LO_W) - 1 - i];
            end
        end
    end

    always_comb begin
        occ = '0;
        for (int k = 0; k < DEPTH; k++) begin
            occ = occ + OCC_W'(vld_q[k]);
        end
    end

endmodule

// File: tb/tb_pipe_chain.sv
// Directed vector table plus hand sequences for pipe_chain, and a queue-model
// stress run on a single-stage byte-wide instance.
module tb_pipe_chain;

    logic       clk = 1'b0;
    logic       rst_l = 1'b0;

    // Default-parameter instance and its REV_LO = 0 twin share stimulus.
    logic       a_vld = 1'b0, a_flush = 1'b0, a_ordy = 1'b0;
    logic [5:0] a_data = '0;
    logic       a_rdy, a_ovld, c_rdy, c_ovld;
    logic [5:0] a_odata, c_odata;
    logic [1:0] a_occ, c_occ;

    // Single-stage byte-wide instance.
    logic       b_vld = 1'b0, b_ordy = 1'b0;
    logic [7:0] b_data = '0;
    logic       b_rdy, b_ovld;
    logic [7:0] b_odata;
    logic       b_occ;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_chain u_a (
        .clk(clk), .rst_l(rst_l), .in_vld(a_vld), .in_rdy(a_rdy), .in_data(a_data),
        .flush(a_flush), .out_vld(a_ovld), .out_rdy(a_ordy), .out_data(a_odata), .occ(a_occ)
    );

    pipe_chain #(.REV_LO(0)) u_c (
        .clk(clk), .rst_l(rst_l), .in_vld(a_vld), .in_rdy(c_rdy), .in_data(a_data),
        .flush(a_flush), .out_vld(c_ovld), .out_rdy(a_ordy), .out_data(c_odata), .occ(c_occ)
    );

    pipe_chain #(.WIDTH(8), .DEPTH(1), .LO_W(8)) u_b (
        .clk(clk), .rst_l(rst_l), .in_vld(b_vld), .in_rdy(b_rdy), .in_data(b_data),
        .flush(1'b0), .out_vld(b_ovld), .out_rdy(b_ordy), .out_data(b_odata), .occ(b_occ)
    );

    typedef struct {
        logic       vld;
        logic [5:0] data;
        logic       ordy;
        logic       flush;
        logic       e_rdy;
        logic       e_ovld;
        logic [5:0] e_odata;
        logic [1:0] e_occ;
    } vec_t;

    function automatic logic [5:0] rev6(input logic [5:0] x);
        return {x[5:3], x[0], x[1], x[2]};
    endfunction

    function automatic logic [7:0] rev8(input logic [7:0] x);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = x[7-i];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    vec_t tbl[12];
    logic [7:0] q[$];
    logic [5:0] words[8];

    initial begin
        // in_vld, in_data, out_rdy, flush | in_rdy, out_vld, out_data, occ
        tbl[0]  = '{1'b1, 6'b101110, 1'b1, 1'b0, 1'b1, 1'b0, 6'h00, 2'd0};
        tbl[1]  = '{1'b0, 6'h00,     1'b1, 1'b0, 1'b1, 1'b0, 6'h00, 2'd1};
        tbl[2]  = '{1'b0, 6'h00,     1'b1, 1'b0, 1'b1, 1'b1, 6'b101011, 2'd1};
        tbl[3]  = '{1'b0, 6'h00,     1'b1, 1'b0, 1'b1, 1'b0, 6'b101011, 2'd0};
        tbl[4]  = '{1'b1, 6'h01,     1'b0, 1'b0, 1'b1, 1'b0, 6'b101011, 2'd0};
        tbl[5]  = '{1'b1, 6'h02,     1'b0, 1'b0, 1'b1, 1'b0, 6'b101011, 2'd1};
        tbl[6]  = '{1'b1, 6'h03,     1'b0, 1'b0, 1'b0, 1'b1, 6'h04, 2'd2};
        tbl[7]  = '{1'b1, 6'h03,     1'b0, 1'b0, 1'b0, 1'b1, 6'h04, 2'd2};
        tbl[8]  = '{1'b1, 6'h03,     1'b1, 1'b0, 1'b1, 1'b1, 6'h04, 2'd2};
        tbl[9]  = '{1'b0, 6'h00,     1'b1, 1'b0, 1'b1, 1'b1, 6'h02, 2'd2};
        tbl[10] = '{1'b0, 6'h00,     1'b1, 1'b0, 1'b1, 1'b1, 6'h06, 2'd1};
        tbl[11] = '{1'b0, 6'h00,     1'b1, 1'b0, 1'b1, 1'b0, 6'h06, 2'd0};
        for (int i = 0; i < 8; i++) words[i] = 6'((i + 1) * 7);

        // Reset state while rst_l is held low.
        #3;
        chk("reset in_rdy", 32'(a_rdy), 0);
        chk("reset out_vld", 32'(a_ovld), 0);
        chk("reset out_data", 32'(a_odata), 0);
        chk("reset occ", 32'(a_occ), 0);
        chk("reset b in_rdy", 32'(b_rdy), 0);
        @(negedge clk);
        rst_l = 1'b1;

        for (int i = 0; i < 12; i++) begin
            a_vld = tbl[i].vld; a_data = tbl[i].data;
            a_ordy = tbl[i].ordy; a_flush = tbl[i].flush;
            #1;
            chk($sformatf("row%0d in_rdy", i), 32'(a_rdy), 32'(tbl[i].e_rdy));
            chk($sformatf("row%0d out_vld", i), 32'(a_ovld), 32'(tbl[i].e_ovld));
            chk($sformatf("row%0d out_data", i), 32'(a_odata), 32'(tbl[i].e_odata));
            chk($sformatf("row%0d occ", i), 32'(a_occ), 32'(tbl[i].e_occ));
            chk($sformatf("row%0d norev out_data", i), 32'(c_odata),
                32'(rev6(tbl[i].e_odata)));
            @(negedge clk);
        end

        // Back-to-back stream of 8 words: no bubbles, order kept.
        for (int c = 0; c < 10; c++) begin
            a_vld = (c < 8); a_data = (c < 8) ? words[c] : 6'h00; a_ordy = 1'b1;
            #1;
            chk($sformatf("stream%0d in_rdy", c), 32'(a_rdy), 1);
            chk($sformatf("stream%0d occ", c), 32'(a_occ),
                (c == 0) ? 0 : ((c == 1 || c == 9) ? 1 : 2));
            if (c >= 2) begin
                chk($sformatf("stream%0d out_vld", c), 32'(a_ovld), 1);
                chk($sformatf("stream%0d out_data", c), 32'(a_odata), 32'(rev6(words[c-2])));
            end
            @(negedge clk);
        end
        a_vld = 1'b0;
        #1;
        chk("stream drained", 32'(a_ovld), 0);
        @(negedge clk);

        // Fill, then flush with the head word leaving and a word offered.
        a_vld = 1'b1; a_data = 6'h11; a_ordy = 1'b0;
        @(negedge clk);
        a_data = 6'h22;
        @(negedge clk);
        a_data = 6'h33; a_ordy = 1'b1; a_flush = 1'b1;
        #1;
        chk("flush in_rdy", 32'(a_rdy), 0);
        chk("flush head out_vld", 32'(a_ovld), 1);
        chk("flush head out_data", 32'(a_odata), 32'(rev6(6'h11)));
        chk("flush occ before", 32'(a_occ), 2);
        @(negedge clk);
        a_flush = 1'b0; a_vld = 1'b0;
        #1;
        chk("flush occ after", 32'(a_occ), 0);
        chk("flush out_vld after", 32'(a_ovld), 0);
        @(negedge clk);
        #1;
        chk("flush no leftover", 32'(a_ovld), 0);
        @(negedge clk);

        // Asynchronous reset in the middle of a full pipeline.
        a_vld = 1'b1; a_data = 6'h2d; a_ordy = 1'b0;
        @(negedge clk);
        a_data = 6'h1e;
        @(negedge clk);
        #1;
        chk("pre-reset occ", 32'(a_occ), 2);
        #1;
        rst_l = 1'b0;
        #1;
        chk("async rst out_vld", 32'(a_ovld), 0);
        chk("async rst occ", 32'(a_occ), 0);
        chk("async rst out_data", 32'(a_odata), 0);
        chk("async rst in_rdy", 32'(a_rdy), 0);
        a_vld = 1'b0; a_ordy = 1'b1;
        @(negedge clk);
        rst_l = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk($sformatf("post-rst%0d out_vld", c), 32'(a_ovld), 0);
            chk($sformatf("post-rst%0d occ", c), 32'(a_occ), 0);
            @(negedge clk);
        end

        // Single-stage instance against a reference queue.
        for (int c = 0; c < 300; c++) begin
            logic e_rdy, do_in, do_out;
            b_vld = 1'($urandom_range(0, 1));
            b_ordy = 1'($urandom_range(0, 1));
            b_data = 8'($urandom);
            #1;
            e_rdy = (q.size() == 0) || b_ordy;
            chk($sformatf("b%0d in_rdy", c), 32'(b_rdy), 32'(e_rdy));
            chk($sformatf("b%0d out_vld", c), 32'(b_ovld), 32'(q.size() != 0));
            chk($sformatf("b%0d occ", c), 32'(b_occ), 32'(q.size()));
            if (q.size() != 0) chk($sformatf("b%0d out_data", c), 32'(b_odata), 32'(rev8(q[0])));
            do_out = (q.size() != 0) && b_ordy;
            do_in = b_vld && e_rdy;
            @(negedge clk);
            if (do_out) void'(q.pop_front());
            if (do_in) q.push_back(b_data);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_chain.md
PIPE_CHAIN -- requirements
Module: pipe_chain

Interface
REQ-001 The block SHALL have parameter WIDTH, default 6, meaning data width in bits (>=2).
REQ-002 The block SHALL have parameter DEPTH, default 2, meaning number of register stages (>=1).
REQ-003 The block SHALL have parameter LO_W, default 3, meaning width of the low field [LO_W-1:0] (1..WIDTH).
REQ-004 The block SHALL have parameter REV_LO, default 1, meaning 1 = bit-reverse the low field at the output, 0 = pass unchanged.
REQ-005 The block SHALL have port clk, input, 1 bit, the single clock; all state on rising edge.
REQ-006 The block SHALL have port rst_l, input, 1 bit, the reset: asynchronous assert, active-low.
REQ-007 The block SHALL have port in_vld, input, 1 bit, meaning upstream word valid.
REQ-008 The block SHALL have port in_rdy, output, 1 bit, meaning the block accepts a word this cycle.
REQ-009 The block SHALL have port in_data, input, WIDTH bits, meaning upstream word.
REQ-010 The block SHALL have port flush, input, 1 bit, meaning synchronous discard of all held words.
REQ-011 The block SHALL have port out_vld, output, 1 bit, meaning the last stage holds a word.
REQ-012 The block SHALL have port out_rdy, input, 1 bit, meaning downstream accepts.
REQ-013 The block SHALL have port out_data, output, WIDTH bits, meaning the transformed last-stage word.
REQ-014 The block SHALL have port occ, output, $clog2(DEPTH+1) bits, meaning the count of valid stages.

Function
REQ-015 The block SHALL hold, per stage k (0..DEPTH-1), one valid bit vld[k] and one WIDTH-bit data register dat[k].
REQ-016 The block SHALL compute stage ready rdy[k] = !vld[k] | rdy[k+1], with rdy[DEPTH] = out_rdy; in_rdy = rdy[0] & !flush.
REQ-017 The block SHALL, when rdy[k] = 1, load stage k each edge from stage k-1 (stage 0 from in_vld/in_data qualified by in_rdy); when rdy[k] = 0, stage k SHALL hold.
REQ-018 The block SHALL treat a transfer as in_vld & in_rdy (input) and out_vld & out_rdy (output); words SHALL never be dropped, duplicated or reordered except by flush/reset.
REQ-019 The block SHALL set out_vld = vld[DEPTH-1]; out_data[WIDTH-1:LO_W] = dat[DEPTH-1][WIDTH-1:LO_W].
REQ-020 The block SHALL drive out_data[LO_W-1:0] as dat[DEPTH-1] bit-reversed (bit i <- bit LO_W-1-i) when REV_LO = 1, else unchanged; the path is combinational from dat[DEPTH-1].
REQ-021 The block SHALL have latency DEPTH cycles: a word accepted at edge n appears on out_vld/out_data after edge n+DEPTH-1, i.e. in cycle n+DEPTH, when out_rdy stays 1.
REQ-022 The block SHALL sustain throughput of one word per cycle with out_rdy = 1 continuously; a simultaneous input and output transfer SHALL be legal when full.
REQ-023 The block SHALL, on flush = 1, clear all vld[] at the next edge; an output transfer in the flush cycle SHALL still complete; no input SHALL be accepted in that cycle.
REQ-024 The block SHALL make occ equal the popcount of vld[] (registered state, not a predicted value); range 0..DEPTH.
REQ-025 The block SHALL not change stage k data when vld[k] = 0 and no load occurs (no spurious toggling).
REQ-026 The block SHALL, with DEPTH = 1, reduce to a single-register skid-free stage; in_rdy = (!vld[0] | out_rdy) & !flush.

Reset
REQ-027 The block SHALL, while rst_l = 0, immediately clear all vld[] and dat[] to 0; out_vld = 0, out_data = 0, occ = 0, in_rdy = 0.
REQ-028 The block SHALL, on rst_l deassertion, accept input from the first edge after deassertion; reset mid-stream SHALL discard all held words.

Verification
REQ-029 Defaults, out_rdy = 1, in_data = 6'b101110 accepted at edge 0 -> out_vld = 1, out_data = 6'b101011 in cycle 2; REV_LO = 0 -> 6'b101110.
REQ-030 out_rdy = 0, offer 3 words back-to-back -> first 2 accepted, in_rdy = 0 thereafter, occ = 2; raise out_rdy -> words exit in order, one per cycle.
REQ-031 Stream 8 words with out_rdy = 1 -> 8 consecutive output transfers, no bubbles, order preserved, occ steady at 2.
REQ-032 Pipeline full, flush = 1 with out_rdy = 1 and in_vld = 1 -> head word transfers, input refused, next cycle occ = 0, out_vld = 0.
REQ-033 rst_l pulled low mid-stream between edges -> out_vld, occ, out_data zero without waiting for clk; after release, no old word reappears.
REQ-034 DEPTH = 1, WIDTH = 8, LO_W = 8 random valid/ready stress vs reference queue model -> zero mismatches, 1-cycle latency.
